// File: rtl/flt_f16_pkg.sv
// flt_f16_pkg: widths, biases, input classes, canonical values and flag indices for FP32->FP16 conversion
package flt_f16_pkg;
    localparam int F32_W    = 32;
    localparam int F16_W    = 16;
    localparam int F32_BIAS = 127;
    localparam int F16_BIAS = 15;
    localparam int FLG_W    = 4;
    localparam int FLG_INV  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_UNF  = 1;
    localparam int FLG_INX  = 0;
    localparam logic [F16_W-1:0] F16_QNAN = 16'h7E00;
    localparam logic [F16_W-1:0] F16_INF  = 16'h7C00;
    typedef enum logic [2:0] {CLS_NAN, CLS_INF, CLS_ZERO, CLS_DENORM, CLS_NORM} cls_t;
    function automatic cls_t classify(input logic [7:0] e, input logic [22:0] m);
        return e == 8'hFF ? (|m ? CLS_NAN : CLS_INF) : e == 8'h00 ? (|m ? CLS_DENORM : CLS_ZERO) : CLS_NORM;
    endfunction
    function automatic logic [FLG_W-1:0] flags(input logic inv, input logic ovf, input logic unf, input logic inx);
        logic [FLG_W-1:0] f;
        f = '0;
        f[FLG_INV] = inv;
        f[FLG_OVF] = ovf;
        f[FLG_UNF] = unf;
        f[FLG_INX] = inx;
        return f;
    endfunction
endpackage

// File: rtl/flt_f16_sync_fifo.sv
// flt_f16_sync_fifo: synchronous FIFO with simultaneous push/pop and occupancy level
// ports: clk, rst (sync, high), push/wdata in, pop in, rdata = head (0 when empty), full, empty, level
module flt_f16_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = level == LVL_W'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/flt_f32_to_f16_buf.sv
// flt_f32_to_f16_buf: FP32 stream -> FP16 (RNE) via 2-stage pipeline and FIFO onto AXI4-Stream with tready
// ports: i_aclk, i_areset (sync, high); i_axi4s_a_* FP32 input (no ready);
//        o_axi4s_result_tdata/tvalid, i_axi4s_result_tready; o_axi4s_result_tuser {inv,ovf,unf,inx}
//        only with FLT_F32_TO_F16_FLAGS_EN; o_fifo_level occupancy; o_drop sticky overflow-loss flag
module flt_f32_to_f16_buf
    import flt_f16_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic [31:0]      i_axi4s_a_tdata,
    input  logic             i_axi4s_a_tvalid,
    output logic [15:0]      o_axi4s_result_tdata,
    output logic             o_axi4s_result_tvalid,
    input  logic             i_axi4s_result_tready,
`ifdef FLT_F32_TO_F16_FLAGS_EN
    output logic [3:0]       o_axi4s_result_tuser,
`endif
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_drop
);
`ifdef FLT_F32_TO_F16_FLAGS_EN
    localparam int W = F16_W + FLG_W;
`else
    localparam int W = F16_W;
`endif
    logic s1_v, s1_s, s2_v, full, empty, pop;
    logic [22:0] s1_m;
    logic signed [9:0] s1_exp;
    cls_t s1_cls;
    logic [W-1:0] s2_w, head;
    logic [23:0] sig;
    logic [47:0] ext;
    logic [9:0] nsh, ebias;
    logic [14:0] mag;
    logic [19:0] cvt;
    logic norm, rem_nz, up, unused;
    always_ff @(posedge i_aclk) begin
        s1_v   <= ~i_areset & i_axi4s_a_tvalid;
        s1_s   <= i_axi4s_a_tdata[F32_W-1];
        s1_m   <= i_axi4s_a_tdata[22:0];
        s1_exp <= 10'(i_axi4s_a_tdata[30:23]) - 10'(F32_BIAS);
        s1_cls <= classify(i_axi4s_a_tdata[30:23], i_axi4s_a_tdata[22:0]);
    end
    // Normal and subnormal share one rounder: normals drop 13 bits, subnormals drop (-1-E) bits
    // so the kept field is already the 10-bit fraction and a rounding carry ripples into the exponent.
    always_comb begin
        sig    = {1'b1, s1_m};
        norm   = s1_exp >= -10'sd14;
        nsh    = -10'sd1 - s1_exp;
        ebias  = s1_exp + 10'(F16_BIAS);
        ext    = {sig, 24'd0} >> (norm ? 5'd13 : nsh[4:0]);
        rem_nz = |ext[23:0];
        up     = ext[23] & ((|ext[22:0]) | ext[24]);
        mag    = {norm ? ebias[4:0] : 5'd0, ext[33:24]} + 15'(up);
        cvt    = s1_cls == CLS_NAN ? {s1_s, F16_QNAN[14:0], flags(1'b1, 1'b0, 1'b0, 1'b0)}
               : s1_cls == CLS_INF ? {s1_s, F16_INF[14:0], flags(1'b0, 1'b0, 1'b0, 1'b0)}
               : s1_cls == CLS_ZERO ? {s1_s, 15'd0, flags(1'b0, 1'b0, 1'b0, 1'b0)}
               : s1_cls == CLS_DENORM || s1_exp < -10'sd25 ? {s1_s, 15'd0, flags(1'b0, 1'b0, 1'b1, 1'b1)}
               : s1_exp > 10'sd15 ? {s1_s, F16_INF[14:0], flags(1'b0, 1'b1, 1'b0, 1'b1)}
               : norm ? {s1_s, mag, flags(1'b0, &mag[14:10], 1'b0, rem_nz)}
               : {s1_s, mag, flags(1'b0, 1'b0, rem_nz, rem_nz)};
    end
    assign unused = ^{ext[47:34], nsh[9:5], ebias[9:5], cvt[3:0]};
    always_ff @(posedge i_aclk) begin
        s2_v <= ~i_areset & s1_v;
        s2_w <= cvt[19 -: W];
    end
    assign o_axi4s_result_tvalid = ~empty;
    assign pop = ~empty & i_axi4s_result_tready;
    flt_f16_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk(i_aclk), .rst(i_areset), .push(s2_v), .pop(pop), .wdata(s2_w),
        .rdata(head), .full(full), .empty(empty), .level(o_fifo_level)
    );
`ifdef FLT_F32_TO_F16_FLAGS_EN
    assign o_axi4s_result_tdata = head[W-1:FLG_W];
    assign o_axi4s_result_tuser = head[FLG_W-1:0];
`else
    assign o_axi4s_result_tdata = head;
`endif
    always_ff @(posedge i_aclk) begin
        if (i_areset) o_drop <= 1'b0;
        else if (s2_v & full & ~pop) o_drop <= 1'b1;
    end
endmodule

// File: tb/tb_flt_f32_to_f16_buf.sv
// tb_flt_f32_to_f16_buf: directed + random checks of the FP32->FP16 buffer against a behavioural model
module tb_flt_f32_to_f16_buf;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;
    logic clk = 0;
    logic rst, in_valid, tready;
    logic [31:0] in_data;
    logic [15:0] tdata;
    logic tvalid, drop;
    logic [LW-1:0] level;
    logic [3:0] tuser;
    int n_pass = 0, n_tot = 0;
    bit armed = 0;
    logic [19:0] fq[$];
    logic [19:0] p1_w, p2_w;
    bit p1_v = 0, p2_v = 0, drop_m = 0;

    flt_f32_to_f16_buf #(.FIFO_DEPTH(DEPTH)) dut (
        .i_aclk(clk), .i_areset(rst),
        .i_axi4s_a_tdata(in_data), .i_axi4s_a_tvalid(in_valid),
        .o_axi4s_result_tdata(tdata), .o_axi4s_result_tvalid(tvalid),
        .i_axi4s_result_tready(tready),
`ifdef FLT_F32_TO_F16_FLAGS_EN
        .o_axi4s_result_tuser(tuser),
`endif
        .o_fifo_level(level), .o_drop(drop)
    );
`ifndef FLT_F32_TO_F16_FLAGS_EN
    assign tuser = 4'd0;
`endif

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Value-level conversion: count quanta of the target grid and round the remainder to nearest-even.
    function automatic logic [19:0] model(input logic [31:0] x);
        logic s, inx;
        int e, ee, big_e, sh;
        longint sig, q, r, half;
        s = x[31];
        e = int'(x[30:23]);
        big_e = e - 127;
        if (e == 255) return (x[22:0] != 0) ? {s, 15'h7E00, 4'b1000} : {s, 15'h7C00, 4'b0000};
        if (e == 0) return (x[22:0] != 0) ? {s, 15'h0, 4'b0011} : {s, 15'h0, 4'b0000};
        if (big_e > 15) return {s, 15'h7C00, 4'b0101};
        if (big_e < -25) return {s, 15'h0, 4'b0011};
        sig = longint'({1'b1, x[22:0]});
        sh = (big_e >= -14) ? 13 : -1 - big_e;
        q = sig >> sh;
        r = sig - (q << sh);
        half = longint'(1) << (sh - 1);
        inx = r != 0;
        if (r > half || (r == half && q % 2 == 1)) q++;
        if (big_e < -14) return {s, 15'(q), 2'b00, inx, inx};
        ee = big_e + 15;
        if (q == 2048) begin
            q = 1024;
            ee++;
        end
        if (ee == 31) return {s, 15'h7C00, 4'b0101};
        return {s, 5'(ee), 10'(q - 1024), 3'b000, inx};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            p1_v <= 0;
            p2_v <= 0;
            drop_m <= 0;
            fq.delete();
        end else begin
            if (fq.size() > 0 && tready) void'(fq.pop_front());
            if (p2_v) begin
                if (fq.size() < DEPTH) fq.push_back(p2_w);
                else drop_m <= 1;
            end
            p2_v <= p1_v;
            p2_w <= p1_w;
            p1_v <= in_valid;
            p1_w <= model(in_data);
        end
    end

    always @(negedge clk) if (armed) begin
        chk("tvalid", 32'(tvalid), 32'(fq.size() != 0));
        chk("level", 32'(level), 32'(fq.size()));
        chk("drop", 32'(drop), 32'(drop_m));
        if (fq.size() != 0) begin
            chk("tdata", 32'(tdata), 32'(fq[0][19:4]));
`ifdef FLT_F32_TO_F16_FLAGS_EN
            chk("tuser", 32'(tuser), 32'(fq[0][3:0]));
`endif
        end
    end

    task automatic send_one(input logic [31:0] x, input logic [15:0] eh, input logic [3:0] ef);
        chk("model_pin", 32'(model(x)), 32'({eh, ef}));
        tready = 1;
        in_valid = 1;
        in_data = x;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("lat_early", 32'(tvalid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(tvalid), 32'd1);
        chk("vec_data", 32'(tdata), 32'(eh));
`ifdef FLT_F32_TO_F16_FLAGS_EN
        chk("vec_flags", 32'(tuser), 32'(ef));
`endif
        @(negedge clk);
    endtask

    logic [31:0] vin[12] = '{32'h3F800000, 32'h477FE000, 32'h477FF000, 32'h3F802000, 32'h3F801000, 32'h3F803000,
                             32'h7FC00001, 32'hFF800000, 32'h33800000, 32'h33000000, 32'h387FE000, 32'h80000001};
    logic [15:0] vout[12] = '{16'h3C00, 16'h7BFF, 16'h7C00, 16'h3C01, 16'h3C00, 16'h3C02,
                              16'h7E00, 16'hFC00, 16'h0001, 16'h0000, 16'h0400, 16'h8000};
    logic [3:0] vflg[12] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 4'b0001,
                             4'b1000, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011};

    initial begin
        rst = 1;
        in_valid = 0;
        in_data = 0;
        tready = 0;
        repeat (2) @(negedge clk);
        armed = 1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) send_one(vin[i], vout[i], vflg[i]);
        // random streaming at full rate
        tready = 1;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1;
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 0;
        repeat (4) @(negedge clk);
        chk("stream_drop", 32'(drop), 32'd0);
        chk("stream_level", 32'(level), 32'd0);
        // push and pop while full
        tready = 0;
        for (int i = 0; i < 23; i++) begin
            in_valid = i < 20;
            in_data = 32'h3F800000 + (i << 13);
            tready = i >= 18 && i < 22;
            if (i >= 18) chk("full_level", 32'(level), 32'd16);
            @(negedge clk);
        end
        in_valid = 0;
        tready = 0;
        chk("full_drop", 32'(drop), 32'd0);
        chk("full_level_end", 32'(level), 32'd16);
        tready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("full_order", 32'(tdata), 32'h3C04 + k);
            @(negedge clk);
        end
        chk("full_empty", 32'(tvalid), 32'd0);
        // backpressure with overflow
        tready = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            in_data = 32'h3F800000 + (i << 13);
            @(negedge clk);
        end
        in_valid = 0;
        repeat (2) @(negedge clk);
        chk("bp_level", 32'(level), 32'd16);
        chk("bp_nodrop", 32'(drop), 32'd0);
        in_valid = 1;
        in_data = 32'h3F800000 + (16 << 13);
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        chk("bp_drop", 32'(drop), 32'd1);
        chk("bp_level_17", 32'(level), 32'd16);
        tready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("bp_order", 32'(tdata), 32'h3C00 + k);
            @(negedge clk);
        end
        chk("bp_empty", 32'(tvalid), 32'd0);
        chk("bp_drop_sticky", 32'(drop), 32'd1);
        // reset mid-stream: 5 buffered, 2 in flight
        tready = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1;
            in_data = 32'h40000000 + (i << 13);
            @(negedge clk);
        end
        in_valid = 0;
        chk("pre_rst_level", 32'(level), 32'd5);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_drop", 32'(drop), 32'd0);
        send_one(32'h3F800000, 16'h3C00, 4'b0000);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
